// File: rtl/serial_addsub_if.sv
// Start/busy/done handshake and operand/result bundle for the serial add/subtract unit.
interface serial_addsub_if #(
    parameter int WIDTH = 16
) ();
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             zero;
    logic             negative;

    modport master (
        output start, op, a, b, cin,
        input  busy, done, result, carry, overflow, zero, negative
    );

    modport slave (
        input  start, op, a, b, cin,
        output busy, done, result, carry, overflow, zero, negative
    );
endinterface

// File: rtl/serial_addsub.sv
// Multi-cycle add/subtract: SLICE bits per clock, LSB slice first, ripple carry held
// in a register between slices; results and N/Z/C/V flags update only on completion.
module serial_addsub #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input logic           clk,
    input logic           rst_n,
    serial_addsub_if.slave bus
);
    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             cy;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] result_r;
    logic             carry_r;
    logic             overflow_r;
    logic             zero_r;
    logic             negative_r;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] part;
    logic [WIDTH-1:0] part_nxt;
    logic [SLICE:0]   sum;
    logic             last;
    logic             accept;

    function automatic logic [SLICE:0] slice_add(input logic [SLICE-1:0] x,
                                                 input logic [SLICE-1:0] y,
                                                 input logic             c);
        return {1'b0, x} + {1'b0, y} + {{SLICE{1'b0}}, c};
    endfunction

    // SUB/SBB become addition of ~b; the initial carry supplies the +1 (or the borrow).
    function automatic logic carry_init(input logic [1:0] op, input logic ci);
        case (op)
            2'b00:   return 1'b0;
            2'b01:   return 1'b1;
            default: return ci;
        endcase
    endfunction

    assign sum    = slice_add(a_sh[SLICE-1:0], b_sh[SLICE-1:0], cy);
    assign last   = (cnt == LAST);
    assign accept = (state == IDLE) && bus.start;

    always_comb begin
        part_nxt = part;
        part_nxt[WIDTH-1 -: SLICE] = sum[SLICE-1:0];
    end

    // Operands shift right so the active slice always sits at bit 0; on the final
    // slice bit SLICE-1 of each holds the original MSB used by the overflow test.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_sh <= bus.a;
            b_sh <= bus.op[0] ? ~bus.b : bus.b;
        end else if (state == RUN) begin
            a_sh <= a_sh >> SLICE;
            b_sh <= b_sh >> SLICE;
            part[int'(cnt) * SLICE +: SLICE] <= sum[SLICE-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            cy         <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            result_r   <= '0;
            carry_r    <= 1'b0;
            overflow_r <= 1'b0;
            zero_r     <= 1'b0;
            negative_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= RUN;
                        busy_r <= 1'b1;
                        cnt    <= '0;
                        cy     <= carry_init(bus.op, bus.cin);
                    end
                end
                RUN: begin
                    cy  <= sum[SLICE];
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        state      <= IDLE;
                        busy_r     <= 1'b0;
                        done_r     <= 1'b1;
                        cnt        <= '0;
                        result_r   <= part_nxt;
                        carry_r    <= sum[SLICE];
                        overflow_r <= (a_sh[SLICE-1] == b_sh[SLICE-1]) &&
                                      (sum[SLICE-1] != a_sh[SLICE-1]);
                        zero_r     <= (part_nxt == '0);
                        negative_r <= sum[SLICE-1];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.result   = result_r;
    assign bus.carry    = carry_r;
    assign bus.overflow = overflow_r;
    assign bus.zero     = zero_r;
    assign bus.negative = negative_r;
endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub (WIDTH=16, SLICE=4): a driver queues expected
// results at issue time and a negedge monitor checks every done pulse and output hold.
module tb_serial_addsub;
    localparam int WIDTH = 16;
    localparam int SLICE = 4;
    localparam int N     = WIDTH / SLICE;

    localparam logic [1:0] ADD = 2'b00;
    localparam logic [1:0] SUB = 2'b01;
    localparam logic [1:0] ADC = 2'b10;
    localparam logic [1:0] SBB = 2'b11;

    typedef struct {
        logic [15:0] r;
        logic        c;
        logic        v;
        logic        z;
        logic        n;
        int          acc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cycle = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t hold;
    exp_t mon_e;

    serial_addsub_if #(.WIDTH(WIDTH)) bus ();

    serial_addsub #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [31:0] out_vec();
        return {10'd0, bus.busy, bus.done, bus.result,
                bus.carry, bus.overflow, bus.zero, bus.negative};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Independent reference built on plain integer arithmetic.
    function automatic exp_t model(input logic [1:0] op, input logic [15:0] a,
                                   input logic [15:0] b, input logic cin);
        exp_t e;
        int ua, ub, sa, sbv, ext, ures, sres;
        ua  = int'(a);
        ub  = int'(b);
        sa  = int'($signed(a));
        sbv = int'($signed(b));
        if (!op[0]) begin
            ext  = (op == ADC) ? int'(cin) : 0;
            ures = ua + ub + ext;
            sres = sa + sbv + ext;
            e.c  = (ures > 65535);
        end else begin
            ext  = (op == SBB) ? int'(!cin) : 0;
            ures = ua - ub - ext;
            sres = sa - sbv - ext;
            e.c  = (ures >= 0);
        end
        e.r   = 16'(ures);
        e.v   = (sres > 32767) || (sres < -32768);
        e.z   = (e.r == 16'h0000);
        e.n   = e.r[15];
        e.acc = 0;
        return e;
    endfunction

    task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic [15:0] r, input logic c,
                         input logic v, input bit keep);
        exp_t e;
        int   w = 0;
        while (bus.busy === 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (bus.busy !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL issue_wait busy=%b required=0", bus.busy);
            return;
        end
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        e.r   = r;
        e.c   = c;
        e.v   = v;
        e.z   = (r == 16'h0000);
        e.n   = r[15];
        e.acc = cycle + 1;
        sb.push_back(e);
        @(negedge clk);
        bus.start = keep;
        bus.op    = 2'($urandom);
        bus.a     = 16'($urandom);
        bus.b     = 16'($urandom);
        bus.cin   = 1'($urandom);
    endtask

    task automatic issue_model(input logic [1:0] op, input logic [15:0] a,
                               input logic [15:0] b, input logic cin);
        exp_t m;
        m = model(op, a, b, cin);
        issue(op, a, b, cin, m.r, m.c, m.v, 1'b0);
    endtask

    // Monitor: pops on every done, otherwise requires outputs to hold their last value.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold = '{r: 16'h0, c: 1'b0, v: 1'b0, z: 1'b0, n: 1'b0, acc: 0};
        end else if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done result=%h required=no_done", bus.result);
            end else begin
                mon_e = sb.pop_front();
                checks++;
                if (bus.result !== mon_e.r) begin
                    errors++;
                    $display("FAIL result actual=%h required=%h", bus.result, mon_e.r);
                end
                checks++;
                if ({bus.carry, bus.overflow, bus.zero, bus.negative} !==
                    {mon_e.c, mon_e.v, mon_e.z, mon_e.n}) begin
                    errors++;
                    $display("FAIL flags_cvzn result=%h actual=%b%b%b%b required=%b%b%b%b",
                             mon_e.r, bus.carry, bus.overflow, bus.zero, bus.negative,
                             mon_e.c, mon_e.v, mon_e.z, mon_e.n);
                end
                checks++;
                if (cycle - mon_e.acc != N) begin
                    errors++;
                    $display("FAIL latency actual=%0d required=%0d", cycle - mon_e.acc, N);
                end
                hold = mon_e;
            end
        end else begin
            checks++;
            if ({bus.result, bus.carry, bus.overflow, bus.zero, bus.negative} !==
                {hold.r, hold.c, hold.v, hold.z, hold.n}) begin
                errors++;
                $display("FAIL output_hold actual=%h/%b%b%b%b required=%h/%b%b%b%b",
                         bus.result, bus.carry, bus.overflow, bus.zero, bus.negative,
                         hold.r, hold.c, hold.v, hold.z, hold.n);
            end
        end
    end

    initial begin
        int w;
        bus.start = 1'b0;
        bus.op    = ADD;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;

        @(negedge clk);
        chk("reset_outputs", out_vec(), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(ADD, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        issue(ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        issue(SUB, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        issue(SUB, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        issue(ADC, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
        issue(SBB, 16'h0005, 16'h0003, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0);
        issue(SBB, 16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);
        issue(SUB, 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        issue(SUB, 16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        issue(ADD, 16'h8000, 16'h8000, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);
        issue(ADC, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);

        // A start pulse mid-run must be dropped.
        issue(ADD, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0);
        bus.start = 1'b1;
        bus.a     = 16'hFFFF;
        bus.b     = 16'hFFFF;
        @(negedge clk);
        bus.start = 1'b0;

        // start held high: each op is accepted in the done cycle of the previous one.
        issue(ADD, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b1);
        issue(ADD, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b1);
        issue(ADD, 16'h0F00, 16'h0100, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1);
        issue(ADD, 16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
        w = 0;
        while (bus.busy === 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        bus.start = 1'b0;
        @(negedge clk);

        // Abort during slice 2.
        issue(ADD, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("abort_outputs", out_vec(), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_done", out_vec(), 32'h0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        issue(ADD, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            issue_model(2'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
        end

        w = 0;
        while (sb.size() > 0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
